tristate_bus_arbiter: RTL

// - Shares one tristate line among N gated drivers. Each driver is a notif0/bufif-style

---
 rtl/tristate_bus_arbiter_pkg.sv | 15 +
 rtl/rr_picker.sv | 31 +++
 rtl/tristate_bus_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types for the tristate bus arbiter and its bench.
// State encodings are fixed so the bench can reason about them.
package tristate_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Purely combinational; reusable for any shared resource.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N < 2) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_onehot_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    int j;

    always_comb begin
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        any_o        = 1'b0;
        j            = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[j]) begin
                any_o           = 1'b1;
                gnt_onehot_o[j] = 1'b1;
                gnt_idx_o       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of one shared tristate line with bounded tenure
// and dead cycles between owners; all outputs registered.
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         drive_en,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     bus_busy,
    output logic                     preempt
);

    localparam int IW = cnt_w(N_REQ);
    localparam int HW = cnt_w(MAX_HOLD);
    localparam int TW = cnt_w(TURNAROUND);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] drive_en_q, drive_en_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;

    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [IW-1:0]    owner_nxt;

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req_i        (req),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (pick_oh),
        .gnt_idx_o    (pick_idx),
        .any_o        (pick_any)
    );

    assign owner_nxt = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        drive_en_d = drive_en_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        preempt_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = OWN;
                    drive_en_d = pick_oh;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            OWN: begin
                // A voluntary release wins over expiry: no preempt pulse then.
                if (!req[owner_q]) begin
                    state_d    = TURN;
                    drive_en_d = '0;
                    rr_ptr_d   = owner_nxt;
                    turn_cnt_d = '0;
                end else if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
                    state_d    = TURN;
                    drive_en_d = '0;
                    rr_ptr_d   = owner_nxt;
                    turn_cnt_d = '0;
                    preempt_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            TURN: begin
                drive_en_d = '0;
                if (turn_cnt_q == TW'(TURNAROUND - 1)) begin
                    state_d    = IDLE;
                    turn_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                drive_en_d = '0;
            end
        endcase
        busy_d = |drive_en_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            drive_en_q <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            drive_en_q <= drive_en_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
        end
    end

    assign drive_en = drive_en_q;
    assign owner_id = owner_q;
    assign bus_busy = busy_q;
    assign preempt  = preempt_q;

endmodule
